// File: rtl/keypad_entry.sv
// keypad_entry: debounces the scan decoder's pressed level, turns each new
// press into a one-cycle key event, and assembles "A op B =" into binary
// operands and an opcode offered to the ALU over a valid/ready handshake.
module keypad_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int OP_W            = 14,
  parameter int MAX_DIGITS      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      key_code,
  input  logic            key_pressed,
  output logic            key_strobe,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] operand_a,
  output logic [OP_W-1:0] operand_b,
  output logic [1:0]      op,
  output logic [OP_W-1:0] disp_value
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int DIG_W = $clog2(MAX_DIGITS + 1);
  localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(MAX_DIGITS);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    ISSUE   = 2'd2
  } state_t;

  // debounce / key event state
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic             strobe_q, strobe_d;
  logic [3:0]       code_q, code_d;

  // entry state
  state_t           state_q, state_d;
  logic [OP_W-1:0]  opa_q, opa_d;
  logic [OP_W-1:0]  opb_q, opb_d;
  logic [1:0]       op_q, op_d;
  logic [DIG_W-1:0] cnt_a_q, cnt_a_d;
  logic [DIG_W-1:0] cnt_b_q, cnt_b_d;
  logic             valid_q, valid_d;
  logic [OP_W-1:0]  disp_q, disp_d;

  logic            is_digit, is_opkey, is_eq, is_clr;
  logic [OP_W-1:0] acc_a, acc_b;

  // Debounce counter runs only while the raw level disagrees with the accepted
  // level; a new press is recognised one cycle after the accepted level rises.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (key_pressed != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = key_pressed;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    strobe_d = stable_q & ~stable_dly_q;
    code_d   = strobe_d ? key_code : code_q;
  end

  // Debounce and key-event registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      strobe_q     <= 1'b0;
      code_q       <= '0;
    end else begin
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      strobe_q     <= strobe_d;
      code_q       <= code_d;
    end
  end

  assign is_digit = (code_q <= 4'd9);
  assign is_opkey = (code_q >= 4'd10) && (code_q <= 4'd13);
  assign is_eq    = (code_q == 4'd14);
  assign is_clr   = (code_q == 4'd15);
  assign acc_a    = opa_q * OP_W'(10) + OP_W'(code_q);
  assign acc_b    = opb_q * OP_W'(10) + OP_W'(code_q);

  // Entry FSM next state: clear beats a same-cycle handshake; in ISSUE only
  // clear and the handshake can change anything.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    op_d    = op_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    valid_d = valid_q;
    if (strobe_q && is_clr) begin
      state_d = ENTER_A;
      opa_d   = '0;
      opb_d   = '0;
      op_d    = '0;
      cnt_a_d = '0;
      cnt_b_d = '0;
      valid_d = 1'b0;
    end else if (state_q == ISSUE) begin
      if (out_ready) begin
        state_d = ENTER_A;
        opa_d   = '0;
        opb_d   = '0;
        cnt_a_d = '0;
        cnt_b_d = '0;
        valid_d = 1'b0;
      end
    end else if (strobe_q) begin
      case (state_q)
        ENTER_A: begin
          if (is_digit) begin
            if (cnt_a_q < DIG_MAX) begin
              opa_d   = acc_a;
              cnt_a_d = cnt_a_q + 1'b1;
            end
          end else if (is_opkey) begin
            op_d    = 2'(code_q - 4'd10);
            state_d = ENTER_B;
          end
        end
        ENTER_B: begin
          if (is_digit) begin
            if (cnt_b_q < DIG_MAX) begin
              opb_d   = acc_b;
              cnt_b_d = cnt_b_q + 1'b1;
            end
          end else if (is_opkey) begin
            if (cnt_b_q == '0) begin
              op_d = 2'(code_q - 4'd10);
            end
          end else if (is_eq) begin
            if (cnt_b_q != '0) begin
              state_d = ISSUE;
              valid_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    disp_d = (state_d == ENTER_A) ? opa_d : opb_d;
  end

  // Entry FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ENTER_A;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      valid_q <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      valid_q <= valid_d;
      disp_q  <= disp_d;
    end
  end

  assign key_strobe = strobe_q;
  assign out_valid  = valid_q;
  assign operand_a  = opa_q;
  assign operand_b  = opb_q;
  assign op         = op_q;
  assign disp_value = disp_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: directed plan followed by random key presses, checked
// against a calculator-level model of the keypad entry rules.
module tb_keypad_entry;
  localparam int DEB  = 4;
  localparam int OP_W = 14;
  localparam int MAXD = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      key_code;
  logic            key_pressed;
  logic            key_strobe;
  logic            out_valid;
  logic            out_ready;
  logic [OP_W-1:0] operand_a;
  logic [OP_W-1:0] operand_b;
  logic [1:0]      op;
  logic [OP_W-1:0] disp_value;

  keypad_entry #(
    .DEBOUNCE_CYCLES(DEB),
    .OP_W(OP_W),
    .MAX_DIGITS(MAXD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_code(key_code),
    .key_pressed(key_pressed),
    .key_strobe(key_strobe),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .op(op),
    .disp_value(disp_value)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int strobe_cnt = 0;
  int exp_strobes = 0;

  // calculator model: m_st 0 = entering A, 1 = entering B, 2 = waiting for ALU
  int m_a, m_b, m_op, m_ca, m_cb, m_st;

  always @(negedge clk) if (key_strobe === 1'b1) strobe_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".operand_a"}, 32'(operand_a), m_a);
    check({tag, ".operand_b"}, 32'(operand_b), m_b);
    check({tag, ".op"}, 32'(op), m_op);
    check({tag, ".out_valid"}, 32'(out_valid), (m_st == 2) ? 1 : 0);
    check({tag, ".disp_value"}, 32'(disp_value), (m_st == 0) ? m_a : m_b);
    check({tag, ".strobes"}, strobe_cnt, exp_strobes);
    $display("[TB] %s: a=%0d b=%0d op=%0d valid=%0d disp=%0d strobes=%0d",
             tag, operand_a, operand_b, op, out_valid, disp_value, strobe_cnt);
  endtask

  function automatic void model_clear();
    m_a = 0; m_b = 0; m_op = 0; m_ca = 0; m_cb = 0; m_st = 0;
  endfunction

  function automatic void model_key(input int code);
    if (code == 15) begin
      model_clear();
    end else if (m_st == 0) begin
      if (code <= 9) begin
        if (m_ca < MAXD) begin m_a = m_a * 10 + code; m_ca++; end
      end else if (code <= 13) begin
        m_op = code - 10; m_st = 1;
      end
    end else if (m_st == 1) begin
      if (code <= 9) begin
        if (m_cb < MAXD) begin m_b = m_b * 10 + code; m_cb++; end
      end else if (code <= 13) begin
        if (m_cb == 0) m_op = code - 10;
      end else if (code == 14) begin
        if (m_cb > 0) m_st = 2;
      end
    end
  endfunction

  // Hold a key for 'hold' cycles, release and let everything settle.
  task automatic press(input int code, input int hold);
    key_code = 4'(code);
    key_pressed = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    key_pressed = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    if (hold >= DEB) begin
      exp_strobes++;
      model_key(code);
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    if (m_st == 2) begin
      m_a = 0; m_b = 0; m_ca = 0; m_cb = 0; m_st = 0;
    end
    check_all(tag);
  endtask

  initial begin
    int seen;
    int code;
    int hold;
    int r;
    rst = 1'b1;
    key_code = 4'd0;
    key_pressed = 1'b0;
    out_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all("reset");

    // single held press, then a short glitch
    press(1, 20);
    check_all("press1_held");
    press(7, 2);
    check_all("glitch");

    // 12 + 34 =, held without ready, then transfer
    press(15, 5);
    press(1, 5); press(2, 5); press(10, 5); press(3, 5); press(4, 5); press(14, 5);
    check_all("add_issue");
    repeat (10) @(posedge clk);
    #1;
    check_all("add_hold");
    handshake("add_xfer");

    // fifth digit ignored, op replaced before B digits
    press(1, 6); press(2, 6); press(3, 6); press(4, 6); press(5, 6);
    check_all("max_digits");
    press(11, 6); press(12, 6); press(7, 6); press(14, 6);
    check_all("mul_issue");
    handshake("mul_xfer");

    // E with no B digit ignored; zero B operand allowed
    press(5, 4); press(13, 4); press(14, 4);
    check_all("eq_no_b");
    press(0, 4); press(14, 4);
    check_all("div_issue");

    // clear in the same cycle as ready: no transfer, everything zero
    key_code = 4'd15;
    key_pressed = 1'b1;
    seen = 0;
    for (int i = 0; i < 30 && seen == 0; i++) begin
      @(posedge clk);
      #1;
      if (key_strobe === 1'b1) seen = 1;
    end
    check("clr_strobe_seen", seen, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    key_pressed = 1'b0;
    exp_strobes++;
    model_clear();
    repeat (10) @(posedge clk);
    #1;
    check_all("clr_vs_ready");

    // reset in the middle of debouncing a held key
    press(9, 5);
    check_all("pre_rst");
    key_code = 4'd3;
    key_pressed = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    key_pressed = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_all("rst_mid_debounce");

    // random key presses against the model
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55) code = $urandom_range(0, 9);
      else if (r < 75) code = $urandom_range(10, 13);
      else if (r < 92) code = 14;
      else code = 15;
      if ($urandom_range(0, 4) == 0) hold = $urandom_range(1, DEB - 1);
      else hold = $urandom_range(DEB, DEB + 6);
      press(code, hold);
      check_all($sformatf("rnd%0d_key%0d_h%0d", n, code, hold));
      if (m_st == 2 && $urandom_range(0, 1) == 1) handshake($sformatf("rnd%0d_xfer", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
